// File: rtl/fork_join_any_seq.sv
// Fork/join_any sequencer: parallel lane countdowns, tail task on first join.
// Optional abort port when FJ_DISABLE_FORK_EN is defined.
module fork_join_any_seq #(
  parameter int NUM_LANES = 2,
  parameter int CNT_W     = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [NUM_LANES-1:0]         lane_en,
  input  logic [NUM_LANES*CNT_W-1:0]   lane_dur,
  input  logic [CNT_W-1:0]             tail_dur,
`ifdef FJ_DISABLE_FORK_EN
  input  logic                         abort,
  output logic                         aborted,
`endif
  output logic                         ready,
  output logic [NUM_LANES-1:0]         lane_busy,
  output logic [NUM_LANES-1:0]         lane_done,
  output logic                         tail_start,
  output logic                         tail_busy,
  output logic                         tail_done,
  output logic                         done,
  output logic [$clog2(NUM_LANES):0]   first_lane
);

  localparam int FLW = $clog2(NUM_LANES) + 1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    TAIL
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]     lane_cnt [NUM_LANES];
  logic [CNT_W-1:0]     tail_cnt;
  logic [CNT_W-1:0]     tail_dur_q;

  logic                 accept;
  logic                 abort_hit;
  logic [NUM_LANES-1:0] lane_fin;
  logic [NUM_LANES-1:0] lane_left;
  logic                 join_fire;
  logic [FLW-1:0]       join_idx;
  logic [CNT_W-1:0]     tail_ld;
  logic                 tail_fin;
  logic                 tail_left;
  logic                 all_fin;
  logic                 all_idle;

  assign accept = start && (state == IDLE);

`ifdef FJ_DISABLE_FORK_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Completion decode for the upcoming edge; E0 uses the live inputs.
  always_comb begin
    lane_fin  = '0;
    lane_left = '0;
    join_idx  = '1;
    all_idle  = (tail_cnt == '0);
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept) begin
        lane_fin[i]  = lane_en[i] &&
                       (lane_dur[i*CNT_W +: CNT_W] == '0);
        lane_left[i] = lane_en[i] &&
                       (lane_dur[i*CNT_W +: CNT_W] != '0);
      end else begin
        lane_fin[i]  = (lane_cnt[i] == ONE);
        lane_left[i] = (lane_cnt[i] > ONE);
      end
      if (lane_cnt[i] != '0)
        all_idle = 1'b0;
    end
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (lane_fin[i])
        join_idx = FLW'(i);
    end
    if (accept)
      join_fire = (lane_fin != '0) || (lane_en == '0);
    else
      join_fire = (state == RUN) && (lane_fin != '0);
    tail_ld = accept ? tail_dur : tail_dur_q;
    if (join_fire) begin
      tail_fin  = (tail_ld == '0);
      tail_left = (tail_ld != '0);
    end else begin
      tail_fin  = (tail_cnt == ONE);
      tail_left = (tail_cnt > ONE);
    end
    all_fin = ((lane_fin != '0) || tail_fin) &&
              (lane_left == '0) && !tail_left &&
              (join_fire || (state == TAIL));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept)
              state_nx = join_fire ? TAIL : RUN;
      RUN:  if (join_fire)
              state_nx = TAIL;
      TAIL: if (all_idle)
              state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (abort_hit)
      state_nx = IDLE;
  end

  always_comb begin
    ready     = (state == IDLE);
    tail_busy = (tail_cnt != '0);
    for (int i = 0; i < NUM_LANES; i++)
      lane_busy[i] = (lane_cnt[i] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++)
        lane_cnt[i] <= '0;
      tail_cnt   <= '0;
      tail_dur_q <= '0;
      lane_done  <= '0;
      tail_start <= 1'b0;
      tail_done  <= 1'b0;
      done       <= 1'b0;
      first_lane <= '0;
`ifdef FJ_DISABLE_FORK_EN
      aborted    <= 1'b0;
`endif
    end else begin
      lane_done  <= '0;
      tail_start <= 1'b0;
      tail_done  <= 1'b0;
      done       <= 1'b0;
`ifdef FJ_DISABLE_FORK_EN
      aborted    <= abort_hit;
`endif
      if (abort_hit) begin
        for (int i = 0; i < NUM_LANES; i++)
          lane_cnt[i] <= '0;
        tail_cnt <= '0;
      end else begin
        for (int i = 0; i < NUM_LANES; i++) begin
          if (accept)
            lane_cnt[i] <= lane_en[i] ?
                           lane_dur[i*CNT_W +: CNT_W] : '0;
          else if (lane_cnt[i] != '0)
            lane_cnt[i] <= lane_cnt[i] - ONE;
        end
        if (accept) begin
          tail_dur_q <= tail_dur;
          first_lane <= '0;
        end
        if (join_fire) begin
          tail_cnt   <= tail_ld;
          tail_start <= 1'b1;
          first_lane <= join_idx;
        end else if (tail_cnt != '0) begin
          tail_cnt <= tail_cnt - ONE;
        end
        lane_done <= lane_fin;
        tail_done <= tail_fin;
        done      <= all_fin;
      end
    end
  end

endmodule

// File: tb/tb_fork_join_any_seq.sv
// Directed bench for fork_join_any_seq with NUM_LANES=2, CNT_W=8.
// Abort scenario is built only when FJ_DISABLE_FORK_EN is defined.
module tb_fork_join_any_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  lane_en;
  logic [15:0] lane_dur;
  logic [7:0]  tail_dur;
  logic        ready;
  logic [1:0]  lane_busy;
  logic [1:0]  lane_done;
  logic        tail_start;
  logic        tail_busy;
  logic        tail_done;
  logic        done;
  logic [1:0]  first_lane;
`ifdef FJ_DISABLE_FORK_EN
  logic        abort;
  logic        aborted;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fork_join_any_seq #(
    .NUM_LANES(2),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .lane_en(lane_en),
    .lane_dur(lane_dur),
    .tail_dur(tail_dur),
`ifdef FJ_DISABLE_FORK_EN
    .abort(abort),
    .aborted(aborted),
`endif
    .ready(ready),
    .lane_busy(lane_busy),
    .lane_done(lane_done),
    .tail_start(tail_start),
    .tail_busy(tail_busy),
    .tail_done(tail_done),
    .done(done),
    .first_lane(first_lane)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply a start; returns one ns after E0 (cycle k=0).
  task automatic fork_op(input logic [1:0] en,
                         input logic [7:0] d0,
                         input logic [7:0] d1,
                         input logic [7:0] t);
    start    = 1'b1;
    lane_en  = en;
    lane_dur = {d1, d0};
    tail_dur = t;
    tick();
    start    = 1'b0;
    lane_en  = '0;
    lane_dur = '0;
    tail_dur = '0;
  endtask

  // Check every cycle k=0..n against hand-computed event times
  // (-1 = never). kr >= 0 injects an ignored start at cycle kr.
  task automatic run_scn(input string tag, input int n,
                         input int t0, input int t1,
                         input int tj, input int fl,
                         input int tt, input int td,
                         input int kr);
    for (int k = 0; k <= n; k++) begin
      chk({tag, ".lane_done"}, lane_done,
          {k == t1, k == t0});
      chk({tag, ".lane_busy"}, lane_busy,
          {t1 > 0 && k < t1, t0 > 0 && k < t0});
      chk({tag, ".tail_start"}, tail_start, k == tj);
      chk({tag, ".tail_busy"}, tail_busy,
          k >= tj && k < tt);
      chk({tag, ".tail_done"}, tail_done, k == tt);
      chk({tag, ".done"}, done, k == td);
      chk({tag, ".ready"}, ready, k > td);
      if (k >= tj)
        chk({tag, ".first_lane"}, first_lane, fl);
      if (k == kr) begin
        start    = 1'b1;
        lane_en  = 2'b11;
        lane_dur = {8'd2, 8'd2};
        tail_dur = 8'd1;
      end
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    lane_en  = '0;
    lane_dur = '0;
    tail_dur = '0;
`ifdef FJ_DISABLE_FORK_EN
    abort    = 1'b0;
`endif
    #12;
    chk("rst.ready", ready, 1'b1);
    chk("rst.lane_busy", lane_busy, 2'b00);
    chk("rst.tail_busy", tail_busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.first_lane", first_lane, 2'b00);
    rst_n = 1'b1;
    tick();

    fork_op(2'b11, 8'd20, 8'd10, 8'd30);
    run_scn("basic", 42, 20, 10, 10, 1, 40, 40, -1);

    fork_op(2'b11, 8'd5, 8'd5, 8'd3);
    run_scn("tie", 10, 5, 5, 5, 0, 8, 8, -1);

    fork_op(2'b00, 8'd7, 8'd7, 8'd4);
    run_scn("none", 6, -1, -1, 0, 3, 4, 4, -1);

    fork_op(2'b01, 8'd0, 8'd9, 8'd0);
    run_scn("zero", 3, 0, -1, 0, 0, 0, 0, -1);

    fork_op(2'b11, 8'd20, 8'd10, 8'd30);
    run_scn("busy_start", 42, 20, 10, 10, 1, 40, 40, 3);

    // Asynchronous reset in the middle of an operation.
    fork_op(2'b11, 8'd20, 8'd10, 8'd30);
    for (int k = 0; k < 15; k++)
      tick();
    chk("mid.lane_busy_pre", lane_busy, 2'b01);
    chk("mid.tail_busy_pre", tail_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid.ready", ready, 1'b1);
    chk("mid.lane_busy", lane_busy, 2'b00);
    chk("mid.tail_busy", tail_busy, 1'b0);
    chk("mid.first_lane", first_lane, 2'b00);
    tick();
    tick();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("mid.no_done", done, 1'b0);
      chk("mid.no_lane_done", lane_done, 2'b00);
      chk("mid.ready_after", ready, 1'b1);
    end

`ifdef FJ_DISABLE_FORK_EN
    fork_op(2'b11, 8'd20, 8'd10, 8'd30);
    for (int k = 0; k < 11; k++)
      tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort.aborted", aborted, 1'b1);
    chk("abort.lane_busy", lane_busy, 2'b00);
    chk("abort.tail_busy", tail_busy, 1'b0);
    chk("abort.ready", ready, 1'b1);
    fork_op(2'b01, 8'd2, 8'd0, 8'd1);
    chk("abort.restart_busy", lane_busy, 2'b01);
    chk("abort.restart_ready", ready, 1'b0);
    chk("abort.aborted_clr", aborted, 1'b0);
    tick();
    tick();
    chk("abort.new_lane_done", lane_done, 2'b01);
    chk("abort.new_tail_start", tail_start, 1'b1);
    tick();
    chk("abort.new_done", done, 1'b1);
    for (int k = 0; k < 30; k++) begin
      tick();
      chk("abort.quiet", {lane_done, tail_done, done}, 4'h0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
